// File: rtl/dmem_hs.sv
// Single-port data memory with a handshake and a fixed LATENCY wait before each access.
// Optional DMEM_MISALIGN_TRAP_EN: misaligned accesses are trapped (err=1) instead of aligned down.
module dmem_hs #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  memop,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic accept, fire;

  logic          we_q;
  logic [1:0]    memop_q;
  logic          sext_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;

  logic [31:0] mem [DEPTH];

  // Upper address bits wrap and are intentionally dropped.
  logic [31:AW+2] unused_addr_hi;
  assign unused_addr_hi = addr[31:AW+2];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    fire      = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept    = 1'b1;
          cnt_nxt   = 4'(LATENCY);
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          fire      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= we;
      memop_q <= memop;
      sext_q  <= sign_ext;
      addr_q  <= addr[AW+1:0];
      wdata_q <= wdata;
    end
  end

  logic          is_byte, is_half;
  logic [1:0]    lane;
  logic [3:0]    be;
  logic [31:0]   wlane, word_rd, shifted, load_val;
  logic [AW-1:0] idx;
  logic          trap;

  always_comb begin
    is_byte = (memop_q == 2'b00);
    is_half = (memop_q == 2'b01);
    idx     = addr_q[AW+1:2];
    // Half/word lanes are aligned down; the trap build blocks misaligned ones separately.
    if (is_byte) begin
      lane  = addr_q[1:0];
      be    = 4'b0001 << addr_q[1:0];
      wlane = {4{wdata_q[7:0]}};
    end else if (is_half) begin
      lane  = {addr_q[1], 1'b0};
      be    = addr_q[1] ? 4'b1100 : 4'b0011;
      wlane = {2{wdata_q[15:0]}};
    end else begin
      lane  = 2'b00;
      be    = 4'b1111;
      wlane = wdata_q;
    end
    word_rd = mem[idx];
    shifted = word_rd >> {lane, 3'b000};
    if (is_byte)
      load_val = {{24{sext_q & shifted[7]}}, shifted[7:0]};
    else if (is_half)
      load_val = {{16{sext_q & shifted[15]}}, shifted[15:0]};
    else
      load_val = word_rd;
`ifdef DMEM_MISALIGN_TRAP_EN
    trap = (is_half && addr_q[0]) || (memop_q[1] && (addr_q[1:0] != 2'b00));
`else
    trap = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst && fire && we_q && !trap) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= 32'd0;
      ready <= 1'b0;
    end else begin
      ready <= fire;
      if (fire && !we_q) rdata <= trap ? 32'd0 : load_val;
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= fire & trap;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign busy = (state == WAIT);

endmodule

// File: tb/tb_dmem_hs.sv
// Self-checking bench for dmem_hs: directed vector table, corner sequences, randomized ops vs a byte-array model.
module tb_dmem_hs;
  localparam int DEPTH   = 1024;
  localparam int LATENCY = 2;

  logic        clk = 1'b0;
  logic        rst, req, req0, we, sign_ext;
  logic [1:0]  memop;
  logic [31:0] addr, wdata;
  logic [31:0] rdata, rdata0;
  logic        ready, busy, err, ready0, busy0, err0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_hs #(.DEPTH(DEPTH), .LATENCY(LATENCY)) u_dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .memop(memop), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .busy(busy), .err(err)
  );

  dmem_hs #(.DEPTH(DEPTH), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(we), .memop(memop), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .rdata(rdata0), .ready(ready0), .busy(busy0), .err(err0)
  );

  // Reference model: flat little-endian byte array plus the last load result.
  logic [7:0]  bmem [DEPTH*4];
  logic [31:0] m_rdata = 32'd0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model(input logic w, input logic [1:0] mo, input logic sx, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic e);
    int size, ba;
    logic [31:0] v;
    size = (mo == 2'd0) ? 1 : (mo == 2'd1) ? 2 : 4;
    ba   = int'(a & 32'(DEPTH*4 - 1));
    e    = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    if (ba % size != 0) begin
      e = 1'b1;
      if (!w) m_rdata = 32'd0;
      rd = m_rdata;
      return;
    end
`endif
    ba = ba - ba % size;
    if (w) begin
      for (int i = 0; i < size; i++) bmem[ba+i] = wd[8*i +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < size; i++) v[8*i +: 8] = bmem[ba+i];
      if (size < 4 && sx && v[8*size-1])
        for (int i = size; i < 4; i++) v[8*i +: 8] = 8'hFF;
      m_rdata = v;
    end
    rd = m_rdata;
  endtask

  task automatic access(input logic w, input logic [1:0] mo, input logic sx, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic e, output int lat);
    @(negedge clk);
    we = w; memop = mo; sign_ext = sx; addr = a; wdata = wd; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    lat = -1;
    for (int n = 1; n <= LATENCY + 10; n++) begin
      @(posedge clk); #1;
      if (ready) begin
        lat = n;
        break;
      end
    end
    rd = rdata;
    e  = err;
  endtask

  task automatic op(input string nm, input logic w, input logic [1:0] mo, input logic sx,
                    input logic [31:0] a, input logic [31:0] wd,
                    output logic [31:0] rd, output logic e);
    logic [31:0] mrd;
    logic me;
    int lat;
    access(w, mo, sx, a, wd, rd, e, lat);
    model(w, mo, sx, a, wd, mrd, me);
    check({nm, " latency"}, 32'(lat), 32'(LATENCY + 1));
    check({nm, " rdata"}, rd, mrd);
    check({nm, " err"}, {31'd0, e}, {31'd0, me});
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  memop;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[16];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, mrd;
    logic e, me;
    int lat, pulses;

    vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h10,   32'hDEADBEEF, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 2'd2, 1'b0, 32'h10,   32'h11223344, 32'hDEADBEEF, 1'b0};
    vecs[3]  = '{1'b1, 2'd0, 1'b0, 32'h13,   32'h00000080, 32'hDEADBEEF, 1'b0};
    vecs[4]  = '{1'b0, 2'd0, 1'b1, 32'h13,   32'h0,        32'hFFFFFF80, 1'b0};
    vecs[5]  = '{1'b0, 2'd0, 1'b0, 32'h13,   32'h0,        32'h00000080, 1'b0};
    vecs[6]  = '{1'b0, 2'd2, 1'b0, 32'h10,   32'h0,        32'h80223344, 1'b0};
    vecs[7]  = '{1'b1, 2'd2, 1'b0, 32'h1000, 32'hCAFEF00D, 32'h80223344, 1'b0};
    vecs[8]  = '{1'b0, 2'd2, 1'b0, 32'h0,    32'h0,        32'hCAFEF00D, 1'b0};
    vecs[9]  = '{1'b0, 2'd1, 1'b1, 32'h12,   32'h0,        32'hFFFF8022, 1'b0};
    vecs[10] = '{1'b1, 2'd2, 1'b0, 32'h14,   32'h00000000, 32'hFFFF8022, 1'b0};
    vecs[11] = '{1'b1, 2'd1, 1'b0, 32'h16,   32'hAAAA5678, 32'hFFFF8022, 1'b0};
    vecs[12] = '{1'b0, 2'd2, 1'b0, 32'h14,   32'h0,        32'h56780000, 1'b0};
    vecs[13] = '{1'b0, 2'd1, 1'b0, 32'h16,   32'h0,        32'h00005678, 1'b0};
    vecs[14] = '{1'b0, 2'd0, 1'b1, 32'h11,   32'h0,        32'h00000033, 1'b0};
    vecs[15] = '{1'b0, 2'd3, 1'b1, 32'h10,   32'h0,        32'h80223344, 1'b0};

    rst = 1'b1; req = 1'b0; req0 = 1'b0; we = 1'b0; memop = 2'd0; sign_ext = 1'b0;
    addr = 32'd0; wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset ready", {31'd0, ready}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset err", {31'd0, err}, 32'd0);
    check("reset rdata", rdata, 32'd0);
    check("reset busy0", {31'd0, busy0}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      op($sformatf("vec%0d", i), vecs[i].we, vecs[i].memop, vecs[i].sext, vecs[i].addr,
         vecs[i].wdata, rd, e);
      check($sformatf("vec%0d table rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d table err", i), {31'd0, e}, {31'd0, vecs[i].exp_err});
    end

    // req pulsed during WAIT must be ignored: exactly one ready follows.
    @(negedge clk);
    we = 1'b0; memop = 2'd2; sign_ext = 1'b0; addr = 32'h10; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    pulses = 0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      if (ready) pulses++;
    end
    model(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, mrd, me);
    check("wait req ignored pulses", 32'(pulses), 32'd1);
    check("wait req ignored rdata", rdata, mrd);

    // Reset during WAIT of a store aborts it.
    op("pre abort store", 1'b1, 2'd2, 1'b0, 32'h20, 32'h0, rd, e);
    @(negedge clk);
    we = 1'b1; memop = 2'd2; addr = 32'h20; wdata = 32'h12345678; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    check("abort busy before rst", {31'd0, busy}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort busy after rst", {31'd0, busy}, 32'd0);
    check("abort rdata after rst", rdata, 32'd0);
    m_rdata = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk); #1;
      if (ready) pulses++;
    end
    check("abort no ready", 32'(pulses), 32'd0);
    op("abort reload", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, e);
    check("abort reload value", rd, 32'h00000000);

    // Misaligned half load at 0x21.
    op("mis store", 1'b1, 2'd2, 1'b0, 32'h20, 32'hBEEF1234, rd, e);
    op("mis half load", 1'b0, 2'd1, 1'b0, 32'h21, 32'h0, rd, e);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("mis half rdata", rd, 32'h0);
    check("mis half err", {31'd0, e}, 32'd1);
`else
    check("mis half rdata", rd, 32'h00001234);
    check("mis half err", {31'd0, e}, 32'd0);
`endif

    // LATENCY=0 instance: one store, then req held high for four loads.
    @(negedge clk);
    we = 1'b1; memop = 2'd2; addr = 32'h0; wdata = 32'h5A5AA5A5; req0 = 1'b1;
    @(posedge clk); #1;
    req0 = 1'b0;
    @(posedge clk); #1;
    check("lat0 store ready", {31'd0, ready0}, 32'd1);
    @(negedge clk);
    we = 1'b0; req0 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      check($sformatf("lat0 ready k%0d", k), {31'd0, ready0}, {31'd0, (k % 2 == 0)});
      check($sformatf("lat0 busy k%0d", k), {31'd0, busy0}, {31'd0, (k % 2 == 1)});
      if (k % 2 == 0) begin
        check($sformatf("lat0 rdata k%0d", k), rdata0, 32'h5A5AA5A5);
        check($sformatf("lat0 err k%0d", k), {31'd0, err0}, 32'd0);
      end
    end
    @(negedge clk);
    req0 = 1'b0;

    // Randomized ops confined to 16 words with random wrap-around upper bits.
    for (int i = 0; i < 16; i++)
      op($sformatf("init%0d", i), 1'b1, 2'd2, 1'b0, ($urandom & 32'hFFFFF000) | 32'(i * 4),
         $urandom, rd, e);
    for (int i = 0; i < 80; i++) begin
      op($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
         1'($urandom_range(0, 1)), ($urandom & 32'hFFFFF000) | ($urandom & 32'h3F),
         $urandom, rd, e);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_hs.md
DMEM_HS -- requirements
Module: dmem_hs

Interface
REQ-001 Parameter DEPTH, default 1024, data memory size in 32-bit words (power of two, 16..65536) SHALL be honoured.
REQ-002 Parameter LATENCY, default 2, wait cycles inserted before each access (0..15) SHALL be honoured.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 req  input  1  access request, sampled only while idle.
REQ-006 we  input  1  1 = store, 0 = load.
REQ-007 memop  input  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-008 sign_ext  input  1  loads: 1 = sign-extend, 0 = zero-extend.
REQ-009 addr  input  32  byte address.
REQ-010 wdata  input  32  store data, right-aligned.
REQ-011 rdata  output  32  load result, right-aligned, registered.
REQ-012 ready  output  1  one-cycle completion pulse, registered.
REQ-013 busy  output  1  high while a request is in flight.
REQ-014 err  output  1  misalignment flag, valid with ready.

Function
REQ-015 The FSM SHALL have two states, IDLE and WAIT; busy SHALL equal (state == WAIT).
REQ-016 IDLE with req=1 at an edge: latch we/memop/sign_ext/addr/wdata, load counter with LATENCY, go to WAIT; req=0 keeps IDLE.
REQ-017 WAIT with counter != 0: decrement counter; req SHALL be ignored.
REQ-018 WAIT with counter == 0: perform the access, set ready=1 for exactly the following cycle, return to IDLE.
REQ-019 ready SHALL rise LATENCY+1 cycles after the acceptance edge; a req held high during the ready cycle SHALL be accepted (back-to-back, one idle cycle minimum per access).
REQ-020 Word index SHALL be addr[log2(DEPTH)+1:2]; higher address bits SHALL be ignored (wrap-around).
REQ-021 Little-endian lanes: byte lane = addr[1:0], half lane = addr[1].
REQ-022 Stores SHALL modify only the selected byte/half/word lanes; rdata SHALL be unchanged by stores.
REQ-023 Loads SHALL extract the lane and extend to 32 bits per sign_ext (word ignores sign_ext); rdata SHALL hold until the next load completes.
REQ-024 Misaligned: half with addr[0]=1, or word with addr[1:0] != 00.
REQ-025 err SHALL be 0 for every aligned access.

Reset
REQ-026 rst=1 SHALL force IDLE, counter=0, ready=0, busy=0, err=0, rdata=0 at the next edge; memory contents SHALL NOT be cleared.
REQ-027 Reset during WAIT SHALL abort the request: no memory write, no ready pulse.
REQ-028 rst SHALL take priority over req on the same edge.

Configuration
REQ-029 Macro DMEM_MISALIGN_TRAP_EN defined: a misaligned access SHALL leave memory unchanged, set rdata=0 for loads, and assert err=1 together with ready.
REQ-030 Macro DMEM_MISALIGN_TRAP_EN undefined: misaligned addresses SHALL be aligned down (half: addr[0] forced 0; word: addr[1:0] forced 00), the access SHALL complete normally, and err SHALL be tied to 0.

Verification
REQ-031 LATENCY=2: store word 0xDEADBEEF at 0x10, then load word at 0x10 -> each ready pulses 3 cycles after acceptance, rdata=0xDEADBEEF.
REQ-032 Store byte 0x80 at 0x13 over 0x11223344, then load byte at 0x13 with sign_ext=1 -> 0xFFFFFF80; with sign_ext=0 -> 0x00000080; word at 0x10 = 0x80223344.
REQ-033 LATENCY=0, req held high for 4 loads -> ready pulses every 2nd cycle; req pulses during WAIT are not accepted.
REQ-034 DEPTH=1024: store word 0xCAFEF00D at 0x1000, load from 0x0000 -> 0xCAFEF00D (wrap-around).
REQ-035 Assert rst during WAIT of a word store of 0x12345678 to 0x20 (previously 0) -> no ready pulse, load 0x20 -> 0x00000000.
REQ-036 Half load at 0x21: with DMEM_MISALIGN_TRAP_EN -> err=1, rdata=0; without -> err=0, rdata equals half at 0x20.
